ibex_fetch_req_ctrl: RTL and testbench

Request controller for the instruction fetch FIFO. Issues word-aligned instruction-bus requests, tracks up to NUM_REQS outstanding transactions, and forwards responses into the fetch FIFO. On a branch it clears the FIFO, redirects fetching to the target, and discards stale in-flight responses. It sits between the IF stage (fetch enable, branch), the instruction memory port, and the fetch FIFO push/clear/busy port.

---
 rtl/ibex_fetch_req_ctrl.sv | 131 +++++++++++++
 tb/tb_ibex_fetch_req_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ibex_fetch_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ibex_fetch_req_ctrl
// Purpose  : Instruction-fetch request controller. Issues word-aligned bus
//            requests, tracks up to NUM_REQS outstanding transactions, forwards
//            responses into the fetch FIFO, and on a branch clears the FIFO,
//            redirects fetching and discards stale in-flight responses.
// Ports    : clk_i, rst_ni (sync, active-low)
//            req_i, branch_i, addr_i        - IF stage control / target
//            busy_o                         - request pending or outstanding
//            instr_req_o/addr_o, gnt_i      - bus request channel
//            instr_rvalid/rdata/err_i       - bus response channel (in order)
//            fifo_busy_i, fifo_clear/valid/addr/rdata/err_o - FIFO port
// Revision : 1.0 - initial release
// ============================================================================
module ibex_fetch_req_ctrl #(
    parameter int unsigned NUM_REQS = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_i,
    input  logic                branch_i,
    input  logic [31:0]         addr_i,
    output logic                busy_o,
    output logic                instr_req_o,
    output logic [31:0]         instr_addr_o,
    input  logic                instr_gnt_i,
    input  logic                instr_rvalid_i,
    input  logic [31:0]         instr_rdata_i,
    input  logic                instr_err_i,
    input  logic [NUM_REQS-1:0] fifo_busy_i,
    output logic                fifo_clear_o,
    output logic                fifo_valid_o,
    output logic [31:0]         fifo_addr_o,
    output logic [31:0]         fifo_rdata_o,
    output logic                fifo_err_o
);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_GNT = 1'b1
    } state_e;

    localparam logic [NUM_REQS-1:0] ONE_HOT0 = NUM_REQS'(1);

    state_e              state_q, state_d;
    logic [29:0]         next_addr_q, next_addr_d;
    logic [NUM_REQS-1:0] outst_q, outst_d;
    logic [NUM_REQS-1:0] disc_q, disc_d;
    logic [NUM_REQS-1:0] outst_rev;
    logic [NUM_REQS-1:0] outst_shift, disc_shift;
    logic                wait_gnt;
    logic                fifo_room;
    logic                new_req;
    logic                req_int;
    logic                gnt_acc;
    logic [29:0]         branch_word;

    // Outstanding transactions occupy the FIFO from the top down, so the
    // reversed thermometer lines up with the FIFO's upper-entry busy flags.
    generate
        for (genvar i = 0; i < NUM_REQS; i++) begin : g_rev
            assign outst_rev[i] = outst_q[NUM_REQS-1-i];
        end
    endgenerate

    assign wait_gnt    = (state_q == WAIT_GNT);
    assign fifo_room   = ~&(fifo_busy_i | outst_rev);
    assign new_req     = req_i & (fifo_room | branch_i) & ~outst_q[NUM_REQS-1];
    assign req_int     = wait_gnt | new_req;
    assign gnt_acc     = req_int & instr_gnt_i;
    assign branch_word = addr_i[31:2];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (req_int && !instr_gnt_i) state_d = WAIT_GNT;
            WAIT_GNT: if (instr_gnt_i)             state_d = IDLE;
            default:                               state_d = IDLE;
        endcase
    end

    always_comb begin
        next_addr_d = next_addr_q;
        if (branch_i) begin
            next_addr_d = gnt_acc ? (branch_word + 30'd1) : branch_word;
        end else if (gnt_acc) begin
            next_addr_d = next_addr_q + 30'd1;
        end
    end

    always_comb begin
        outst_shift = instr_rvalid_i ? (outst_q >> 1) : outst_q;
        disc_shift  = instr_rvalid_i ? (disc_q  >> 1) : disc_q;
        outst_d     = gnt_acc ? ((outst_shift << 1) | ONE_HOT0) : outst_shift;
        // A branch marks every survivor of this cycle's retire as stale. The
        // slot granted this cycle is not in outst_shift, so it stays clean.
        disc_d      = branch_i ? outst_shift : disc_shift;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            next_addr_q <= 30'd0;
            outst_q     <= '0;
            disc_q      <= '0;
        end else begin
            state_q     <= state_d;
            next_addr_q <= next_addr_d;
            outst_q     <= outst_d;
            disc_q      <= disc_d;
        end
    end

    // All outputs are held low while reset is asserted.
    assign instr_req_o  = rst_ni & req_int;
    assign instr_addr_o = rst_ni ? {(branch_i ? branch_word : next_addr_q), 2'b00} : 32'd0;
    assign busy_o       = rst_ni & (outst_q[0] | wait_gnt);
    assign fifo_clear_o = rst_ni & branch_i;
    assign fifo_valid_o = rst_ni & instr_rvalid_i & ~disc_q[0] & ~branch_i;
    assign fifo_addr_o  = rst_ni ? addr_i : 32'd0;
    assign fifo_rdata_o = rst_ni ? instr_rdata_i : 32'd0;
    assign fifo_err_o   = rst_ni & instr_err_i;

    a_rvalid_needs_outst : assert property (@(posedge clk_i) disable iff (!rst_ni)
        instr_rvalid_i |-> outst_q[0]);
    a_gnt_needs_req : assert property (@(posedge clk_i) disable iff (!rst_ni)
        instr_gnt_i |-> instr_req_o);

endmodule
`default_nettype wire

// File: tb/tb_ibex_fetch_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ibex_fetch_req_ctrl
// Purpose  : Directed self-checking bench for ibex_fetch_req_ctrl. A queue-
//            based model of outstanding fetches is compared against the DUT
//            every cycle; literal checks pin key addresses and handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ibex_fetch_req_ctrl;

    localparam int NUM_REQS = 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                req = 1'b0, br = 1'b0, gnt = 1'b0, rv = 1'b0, err = 1'b0;
    logic [31:0]         tgt = '0, rdata = '0;
    logic [NUM_REQS-1:0] fbusy = '0;

    logic                busy_o, instr_req_o, fifo_clear_o, fifo_valid_o, fifo_err_o;
    logic [31:0]         instr_addr_o, fifo_addr_o, fifo_rdata_o;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc_n  = 0;

    ibex_fetch_req_ctrl #(.NUM_REQS(NUM_REQS)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_i          (req),
        .branch_i       (br),
        .addr_i         (tgt),
        .busy_o         (busy_o),
        .instr_req_o    (instr_req_o),
        .instr_addr_o   (instr_addr_o),
        .instr_gnt_i    (gnt),
        .instr_rvalid_i (rv),
        .instr_rdata_i  (rdata),
        .instr_err_i    (err),
        .fifo_busy_i    (fbusy),
        .fifo_clear_o   (fifo_clear_o),
        .fifo_valid_o   (fifo_valid_o),
        .fifo_addr_o    (fifo_addr_o),
        .fifo_rdata_o   (fifo_rdata_o),
        .fifo_err_o     (fifo_err_o)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          mq[$];          // discard flag per outstanding fetch, oldest first
    bit          m_pend = 0;     // a request is up but not yet granted
    logic [31:0] m_next = '0;    // byte address of next request
    bit          e_req, e_valid, e_busy;
    logic [31:0] e_addr;

    function automatic void eval_model();
        int c;
        bit room;
        bit disc0;
        c    = mq.size();
        room = 0;
        // Outstanding fetches reserve the top c FIFO entries.
        for (int k = 0; k < NUM_REQS; k++)
            if (!fbusy[k] && k < NUM_REQS - c) room = 1;
        disc0   = 0;
        if (c > 0) disc0 = mq[0];
        e_req   = m_pend || (req && (room || br) && c < NUM_REQS);
        e_addr  = br ? (tgt & ~32'h3) : m_next;
        e_valid = rv && !br && !disc0;
        e_busy  = (c > 0) || m_pend;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_req",   32'(instr_req_o),  32'd0);
                chk("rst_addr",  instr_addr_o,      32'd0);
                chk("rst_busy",  32'(busy_o),       32'd0);
                chk("rst_clear", 32'(fifo_clear_o), 32'd0);
                chk("rst_valid", 32'(fifo_valid_o), 32'd0);
                chk("rst_faddr", fifo_addr_o,       32'd0);
                chk("rst_rdata", fifo_rdata_o,      32'd0);
                chk("rst_err",   32'(fifo_err_o),   32'd0);
            end else begin
                eval_model();
                chk("m_req",   32'(instr_req_o),  32'(e_req));
                chk("m_addr",  instr_addr_o,      e_addr);
                chk("m_busy",  32'(busy_o),       32'(e_busy));
                chk("m_clear", 32'(fifo_clear_o), 32'(br));
                chk("m_valid", 32'(fifo_valid_o), 32'(e_valid));
                chk("m_faddr", fifo_addr_o,       tgt);
                chk("m_rdata", fifo_rdata_o,      rdata);
                chk("m_err",   32'(fifo_err_o),   32'(err));
            end
            @(posedge clk);
            if (!rst_n) begin
                mq.delete();
                m_pend = 0;
                m_next = '0;
            end else begin
                bit g;
                eval_model();
                g = gnt && e_req;
                if (rv && mq.size() > 0) void'(mq.pop_front());
                if (br) foreach (mq[i]) mq[i] = 1'b1;
                if (g) mq.push_back(1'b0);
                m_pend = e_req && !g;
                if (br)     m_next = (tgt & ~32'h3) + (g ? 32'd4 : 32'd0);
                else if (g) m_next = m_next + 32'd4;
            end
        end
    end

    // One bus cycle: inputs change 2 time units after the edge, the grant
    // follows the request 1 unit later, leaving outputs settled for checks.
    task automatic cyc(input logic rs, input logic r, input logic b, input logic [31:0] t,
                       input logic ge, input logic v, input logic [NUM_REQS-1:0] fb);
        @(posedge clk);
        #2;
        rst_n = rs; req = r; br = b; tgt = t; rv = v; fbusy = fb;
        rdata = 32'hC0DE_0000 | 32'(cyc_n);
        err   = cyc_n[0];
        cyc_n++;
        #1;
        gnt = ge & instr_req_o;
    endtask

    initial begin
        // reset with busy inputs: everything held low
        cyc(0, 1, 1, 32'h1234, 1, 1, 2'b00); chk("R0_req", 32'(instr_req_o), 0); chk("R0_valid", 32'(fifo_valid_o), 0);
        cyc(0, 1, 0, 0, 1, 0, 2'b00);
        cyc(1, 0, 0, 0, 0, 0, 2'b00); chk("R1_addr", instr_addr_o, 32'h0); chk("R1_busy", 32'(busy_o), 0);
        // sequential fetch, grant tied high, response one cycle later
        cyc(1, 1, 0, 0, 1, 0, 2'b00); chk("A_addr", instr_addr_o, 32'h0); chk("A_req", 32'(instr_req_o), 1);
        cyc(1, 1, 0, 0, 1, 1, 2'b00); chk("B_addr", instr_addr_o, 32'h4); chk("B_valid", 32'(fifo_valid_o), 1);
        cyc(1, 1, 0, 0, 1, 1, 2'b00); chk("C_addr", instr_addr_o, 32'h8); chk("C_valid", 32'(fifo_valid_o), 1);
        cyc(1, 1, 0, 0, 1, 0, 2'b00); chk("D_addr", instr_addr_o, 32'hC);
        // branch to 0x1002 with two outstanding
        cyc(1, 1, 1, 32'h1002, 1, 0, 2'b00);
        chk("E_clear", 32'(fifo_clear_o), 1); chk("E_faddr", fifo_addr_o, 32'h1002);
        chk("E_addr", instr_addr_o, 32'h1000); chk("E_req", 32'(instr_req_o), 0);
        cyc(1, 1, 0, 0, 1, 1, 2'b00); chk("F_valid", 32'(fifo_valid_o), 0); chk("F_req", 32'(instr_req_o), 0);
        cyc(1, 1, 0, 0, 1, 1, 2'b00); chk("G_valid", 32'(fifo_valid_o), 0); chk("G_addr", instr_addr_o, 32'h1000);
        chk("G_req", 32'(instr_req_o), 1);
        cyc(1, 0, 0, 0, 0, 1, 2'b00); chk("H_valid", 32'(fifo_valid_o), 1);
        // grant withheld with req dropped
        cyc(1, 1, 1, 32'h20, 0, 0, 2'b00); chk("I_req", 32'(instr_req_o), 1); chk("I_addr", instr_addr_o, 32'h20);
        cyc(1, 0, 0, 0, 0, 0, 2'b00); chk("J_req", 32'(instr_req_o), 1); chk("J_addr", instr_addr_o, 32'h20);
        cyc(1, 0, 0, 0, 0, 0, 2'b00); chk("K_req", 32'(instr_req_o), 1); chk("K_busy", 32'(busy_o), 1);
        cyc(1, 0, 0, 0, 1, 0, 2'b00); chk("L_addr", instr_addr_o, 32'h20); chk("L_gnt", 32'(gnt), 1);
        cyc(1, 0, 0, 0, 0, 1, 2'b00); chk("M_busy", 32'(busy_o), 1); chk("M_valid", 32'(fifo_valid_o), 1);
        cyc(1, 0, 0, 0, 0, 0, 2'b00); chk("N_busy", 32'(busy_o), 0); chk("N_req", 32'(instr_req_o), 0);
        // FIFO full, then partial release
        cyc(1, 1, 0, 0, 1, 0, 2'b11); chk("O_req", 32'(instr_req_o), 0);
        cyc(1, 1, 0, 0, 1, 0, 2'b11); chk("P_req", 32'(instr_req_o), 0);
        cyc(1, 1, 0, 0, 1, 0, 2'b01); chk("Q_req", 32'(instr_req_o), 1); chk("Q_addr", instr_addr_o, 32'h24);
        cyc(1, 1, 0, 0, 1, 0, 2'b01); chk("R_req", 32'(instr_req_o), 0);
        cyc(1, 0, 0, 0, 0, 1, 2'b00); chk("S_valid", 32'(fifo_valid_o), 1);
        // outstanding full plus branch to 0x400
        cyc(1, 1, 0, 0, 1, 0, 2'b00); chk("T_addr", instr_addr_o, 32'h28);
        cyc(1, 1, 0, 0, 1, 0, 2'b00); chk("U_addr", instr_addr_o, 32'h2C);
        cyc(1, 1, 1, 32'h400, 1, 0, 2'b00); chk("V_req", 32'(instr_req_o), 0);
        cyc(1, 1, 0, 0, 1, 0, 2'b00); chk("W_req", 32'(instr_req_o), 0);
        cyc(1, 1, 0, 0, 1, 1, 2'b00); chk("X_req", 32'(instr_req_o), 0); chk("X_valid", 32'(fifo_valid_o), 0);
        cyc(1, 1, 0, 0, 1, 1, 2'b00); chk("Y_req", 32'(instr_req_o), 1); chk("Y_addr", instr_addr_o, 32'h400);
        chk("Y_valid", 32'(fifo_valid_o), 0);
        cyc(1, 0, 0, 0, 0, 1, 2'b00); chk("Z_valid", 32'(fifo_valid_o), 1);
        // reset in the middle of a burst
        cyc(1, 1, 0, 0, 1, 0, 2'b00); chk("AA_addr", instr_addr_o, 32'h404);
        cyc(1, 1, 0, 0, 1, 1, 2'b00); chk("AB_addr", instr_addr_o, 32'h408);
        cyc(0, 1, 0, 0, 1, 0, 2'b00); chk("AC_req", 32'(instr_req_o), 0); chk("AC_busy", 32'(busy_o), 0);
        chk("AC_addr", instr_addr_o, 32'h0);
        cyc(1, 1, 0, 0, 1, 0, 2'b00); chk("AD_addr", instr_addr_o, 32'h0); chk("AD_req", 32'(instr_req_o), 1);
        cyc(1, 0, 0, 0, 0, 1, 2'b00); chk("AE_valid", 32'(fifo_valid_o), 1);
        // branch coinciding with a response and a grant
        cyc(1, 1, 0, 0, 1, 0, 2'b00); chk("AF_addr", instr_addr_o, 32'h4);
        cyc(1, 1, 1, 32'h82, 1, 1, 2'b00); chk("AG_valid", 32'(fifo_valid_o), 0);
        chk("AG_clear", 32'(fifo_clear_o), 1); chk("AG_addr", instr_addr_o, 32'h80);
        chk("AG_req", 32'(instr_req_o), 1);
        cyc(1, 0, 0, 0, 0, 1, 2'b00); chk("AH_valid", 32'(fifo_valid_o), 1);
        cyc(1, 1, 0, 0, 1, 0, 2'b00); chk("AI_addr", instr_addr_o, 32'h84);
        cyc(1, 0, 0, 0, 0, 1, 2'b00); chk("AJ_valid", 32'(fifo_valid_o), 1);
        cyc(1, 0, 0, 0, 0, 0, 2'b00); chk("AK_busy", 32'(busy_o), 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
